bc_turn_controller: RTL and testbench

Game sequencer for the two-player Bulls & Cows datapath. It takes secret entry from both players, alternates guesses between J1 and J2, and drives each guess through an external bulls/cows scorer over a req/ack handshake. It applies the per-round win/draw rules and reports turn, phase, last score and final winner to the display logic.

---
 rtl/bc_turn_controller.sv | 183 ++++++++++++++++++
 tb/tb_bc_turn_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bc_turn_controller.sv
// Bulls & Cows game sequencer: secret entry, alternating guesses, scorer handshake,
// and per-round win/draw/timeout decisions. All outputs are registered.
module bc_turn_controller #(
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned MAX_ROUNDS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   entry,
    input  logic                  enter,
    output logic                  cmp_req,
    output logic [4*DIGITS-1:0]   cmp_secret,
    output logic [4*DIGITS-1:0]   cmp_guess,
    input  logic                  cmp_ack,
    input  logic [2:0]            cmp_bulls,
    input  logic [2:0]            cmp_cows,
    output logic                  player,
    output logic [1:0]            phase,
    output logic [3:0]            round,
    output logic [2:0]            last_bulls,
    output logic [2:0]            last_cows,
    output logic                  result_valid,
    output logic                  reject,
    output logic [1:0]            winner,
    output logic                  game_over
);

    typedef enum logic [2:0] {
        StSecret1,
        StSecret2,
        StGuess,
        StScore,
        StEnd
    } state_t;

    localparam logic [1:0] PhSecret = 2'd0;
    localparam logic [1:0] PhGuess  = 2'd1;
    localparam logic [1:0] PhScore  = 2'd2;
    localparam logic [1:0] PhOver   = 2'd3;

    state_t              state;
    logic [4*DIGITS-1:0] secret_j1;
    logic [4*DIGITS-1:0] secret_j2;
    logic                hit_j1;
    logic                entry_valid;
    logic                hit;
    logic [3:0]          round_next;

    assign hit        = (cmp_bulls == 3'(DIGITS));
    assign round_next = round + 4'd1;

    // Entry is valid when every digit is BCD (<= 9) and no two digits repeat.
    always_comb begin
        entry_valid = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (entry[4*i +: 4] > 4'd9) entry_valid = 1'b0;
            for (int j = i + 1; j < int'(DIGITS); j++) begin
                if (entry[4*i +: 4] == entry[4*j +: 4]) entry_valid = 1'b0;
            end
        end
    end

    // Game FSM with registered outputs; reject/result_valid are single-cycle pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= StSecret1;
            secret_j1    <= '0;
            secret_j2    <= '0;
            hit_j1       <= 1'b0;
            cmp_req      <= 1'b0;
            cmp_secret   <= '0;
            cmp_guess    <= '0;
            player       <= 1'b0;
            phase        <= PhSecret;
            round        <= 4'd0;
            last_bulls   <= 3'd0;
            last_cows    <= 3'd0;
            result_valid <= 1'b0;
            reject       <= 1'b0;
            winner       <= 2'b00;
            game_over    <= 1'b0;
        end else begin
            reject       <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                StSecret1: begin
                    if (enter) begin
                        if (entry_valid) begin
                            secret_j1 <= entry;
                            player    <= 1'b1;
                            state     <= StSecret2;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                StSecret2: begin
                    if (enter) begin
                        if (entry_valid) begin
                            secret_j2 <= entry;
                            player    <= 1'b0;
                            round     <= 4'd0;
                            phase     <= PhGuess;
                            state     <= StGuess;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                StGuess: begin
                    if (enter) begin
                        if (entry_valid) begin
                            cmp_guess  <= entry;
                            // Each player is scored against the opponent's secret.
                            cmp_secret <= player ? secret_j1 : secret_j2;
                            cmp_req    <= 1'b1;
                            phase      <= PhScore;
                            state      <= StScore;
                        end else begin
                            reject <= 1'b1;
                        end
                    end
                end
                StScore: begin
                    // cmp_req is high for the whole of this state, so ack is always live here.
                    if (cmp_ack) begin
                        cmp_req      <= 1'b0;
                        last_bulls   <= cmp_bulls;
                        last_cows    <= cmp_cows;
                        result_valid <= 1'b1;
                        if (!player) begin
                            // J2 always gets the answering guess, even after a J1 hit.
                            hit_j1 <= hit;
                            player <= 1'b1;
                            phase  <= PhGuess;
                            state  <= StGuess;
                        end else if (hit_j1 || hit) begin
                            winner    <= {hit, hit_j1};
                            phase     <= PhOver;
                            game_over <= 1'b1;
                            state     <= StEnd;
                        end else begin
                            round <= round_next;
                            if (round_next == 4'(MAX_ROUNDS)) begin
                                winner    <= 2'b00;
                                phase     <= PhOver;
                                game_over <= 1'b1;
                                state     <= StEnd;
                            end else begin
                                player <= 1'b0;
                                phase  <= PhGuess;
                                state  <= StGuess;
                            end
                        end
                    end
                end
                StEnd: begin
                    // Any enter restarts; no validity check here.
                    if (enter) begin
                        secret_j1  <= '0;
                        secret_j2  <= '0;
                        hit_j1     <= 1'b0;
                        cmp_secret <= '0;
                        cmp_guess  <= '0;
                        round      <= 4'd0;
                        last_bulls <= 3'd0;
                        last_cows  <= 3'd0;
                        winner     <= 2'b00;
                        game_over  <= 1'b0;
                        player     <= 1'b0;
                        phase      <= PhSecret;
                        state      <= StSecret1;
                    end
                end
                default: begin
                    state <= StSecret1;
                    phase <= PhSecret;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bc_turn_controller.sv
// Directed bench for bc_turn_controller (DIGITS=4, MAX_ROUNDS=2).
module tb_bc_turn_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] entry = 16'h0;
    logic        enter = 1'b0;
    logic        cmp_req;
    logic [15:0] cmp_secret;
    logic [15:0] cmp_guess;
    logic        cmp_ack = 1'b0;
    logic [2:0]  cmp_bulls = 3'd0;
    logic [2:0]  cmp_cows = 3'd0;
    logic        player;
    logic [1:0]  phase;
    logic [3:0]  round;
    logic [2:0]  last_bulls;
    logic [2:0]  last_cows;
    logic        result_valid;
    logic        reject;
    logic [1:0]  winner;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    bc_turn_controller #(
        .DIGITS     (4),
        .MAX_ROUNDS (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .entry        (entry),
        .enter        (enter),
        .cmp_req      (cmp_req),
        .cmp_secret   (cmp_secret),
        .cmp_guess    (cmp_guess),
        .cmp_ack      (cmp_ack),
        .cmp_bulls    (cmp_bulls),
        .cmp_cows     (cmp_cows),
        .player       (player),
        .phase        (phase),
        .round        (round),
        .last_bulls   (last_bulls),
        .last_cows    (last_cows),
        .result_valid (result_valid),
        .reject       (reject),
        .winner       (winner),
        .game_over    (game_over)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One enter pulse; returns at the following negedge.
    task automatic press(input logic [15:0] code);
        entry = code;
        enter = 1'b1;
        @(negedge clock);
        enter = 1'b0;
    endtask

    // One-cycle ack pulse; returns at the following negedge.
    task automatic ack(input logic [2:0] b, input logic [2:0] c);
        cmp_bulls = b;
        cmp_cows  = c;
        cmp_ack   = 1'b1;
        @(negedge clock);
        cmp_ack   = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_player"}, 32'(player), 32'd0);
        chk({tag, "_round"}, 32'(round), 32'd0);
        chk({tag, "_winner"}, 32'(winner), 32'd0);
        chk({tag, "_req"}, 32'(cmp_req), 32'd0);
        chk({tag, "_secret"}, 32'(cmp_secret), 32'd0);
        chk({tag, "_guess"}, 32'(cmp_guess), 32'd0);
        chk({tag, "_last"}, 32'({last_bulls, last_cows}), 32'd0);
        chk({tag, "_pulses"}, 32'({result_valid, reject}), 32'd0);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
    endtask

    initial begin
        #1;
        check_reset_state("rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Rejects in SECRET1
        press(16'h1123);
        chk("rej_dup", 32'(reject), 32'd1);
        chk("rej_dup_ph", 32'(phase), 32'd0);
        chk("rej_dup_pl", 32'(player), 32'd0);
        @(negedge clock);
        chk("rej_pulse_end", 32'(reject), 32'd0);
        press(16'h12A4);
        chk("rej_bcd", 32'(reject), 32'd1);
        chk("rej_bcd_ph", 32'(phase), 32'd0);
        press(16'h1234);
        chk("acc_s1_rej", 32'(reject), 32'd0);
        chk("acc_s1_pl", 32'(player), 32'd1);
        chk("acc_s1_ph", 32'(phase), 32'd0);
        press(16'h5678);
        chk("acc_s2_ph", 32'(phase), 32'd1);
        chk("acc_s2_pl", 32'(player), 32'd0);
        chk("acc_s2_rd", 32'(round), 32'd0);

        // J1 guess, delayed ack with enter toggling
        press(16'h5678);
        chk("g1_ph", 32'(phase), 32'd2);
        chk("g1_req", 32'(cmp_req), 32'd1);
        chk("g1_guess", 32'(cmp_guess), 32'h5678);
        chk("g1_secret", 32'(cmp_secret), 32'h5678);
        entry = 16'h9876;
        for (int i = 0; i < 5; i++) begin
            enter = (i % 2 == 0);
            @(negedge clock);
            chk("hold_req", 32'(cmp_req), 32'd1);
            chk("hold_guess", 32'(cmp_guess), 32'h5678);
            chk("hold_secret", 32'(cmp_secret), 32'h5678);
            chk("hold_ph", 32'(phase), 32'd2);
            chk("hold_rej", 32'(reject), 32'd0);
        end
        enter = 1'b0;
        ack(3'd4, 3'd0);
        chk("a1_req", 32'(cmp_req), 32'd0);
        chk("a1_pl", 32'(player), 32'd1);
        chk("a1_ph", 32'(phase), 32'd1);
        chk("a1_last", 32'({last_bulls, last_cows}), 32'({3'd4, 3'd0}));
        chk("a1_rv", 32'(result_valid), 32'd1);
        chk("a1_over", 32'(game_over), 32'd0);
        @(negedge clock);
        chk("a1_rv_end", 32'(result_valid), 32'd0);

        // J2 answers, J1 wins
        press(16'h4321);
        chk("g2_secret", 32'(cmp_secret), 32'h1234);
        chk("g2_guess", 32'(cmp_guess), 32'h4321);
        ack(3'd0, 3'd4);
        chk("j1win_w", 32'(winner), 32'd1);
        chk("j1win_over", 32'(game_over), 32'd1);
        chk("j1win_rd", 32'(round), 32'd0);
        chk("j1win_ph", 32'(phase), 32'd3);
        chk("j1win_last", 32'({last_bulls, last_cows}), 32'({3'd0, 3'd4}));
        // Restart from END with an invalid code: no check, no reject
        press(16'h1123);
        chk("rs_ph", 32'(phase), 32'd0);
        chk("rs_w", 32'(winner), 32'd0);
        chk("rs_rd", 32'(round), 32'd0);
        chk("rs_over", 32'(game_over), 32'd0);
        chk("rs_last", 32'({last_bulls, last_cows}), 32'd0);
        chk("rs_rej", 32'(reject), 32'd0);

        // Draw; ack held high before the guess (ignored while cmp_req=0)
        press(16'h1234);
        press(16'h5678);
        cmp_bulls = 3'd4;
        cmp_cows  = 3'd0;
        cmp_ack   = 1'b1;
        @(negedge clock);
        chk("early_ack_ph", 32'(phase), 32'd1);
        chk("early_ack_rv", 32'(result_valid), 32'd0);
        press(16'h5678);
        chk("min_score_req", 32'(cmp_req), 32'd1);
        @(negedge clock);
        cmp_ack = 1'b0;
        chk("min_score_pl", 32'(player), 32'd1);
        chk("min_score_rv", 32'(result_valid), 32'd1);
        press(16'h1234);
        ack(3'd4, 3'd0);
        chk("draw_w", 32'(winner), 32'd3);
        chk("draw_over", 32'(game_over), 32'd1);
        press(16'h0000);

        // Timeout at MAX_ROUNDS=2
        press(16'h1234);
        press(16'h5678);
        for (int r = 0; r < 2; r++) begin
            press(16'h0123);
            ack(3'd1, 3'd1);
            chk("to_pl1", 32'(player), 32'd1);
            press(16'h3210);
            ack(3'd1, 3'd1);
            chk("to_rd", 32'(round), 32'(r + 1));
        end
        chk("to_w", 32'(winner), 32'd0);
        chk("to_over", 32'(game_over), 32'd1);
        chk("to_ph", 32'(phase), 32'd3);
        chk("to_last", 32'({last_bulls, last_cows}), 32'({3'd1, 3'd1}));
        press(16'h0000);
        chk("to_rs_ph", 32'(phase), 32'd0);

        // Enter held two cycles: both secrets take the same value
        entry = 16'h2468;
        enter = 1'b1;
        @(negedge clock);
        @(negedge clock);
        enter = 1'b0;
        chk("held_ph", 32'(phase), 32'd1);
        chk("held_pl", 32'(player), 32'd0);
        press(16'h1357);
        chk("held_secret", 32'(cmp_secret), 32'h2468);

        // Reset mid-SCORE, then a late ack
        reset = 1'b1;
        #1;
        chk("rst_mid_req", 32'(cmp_req), 32'd0);
        check_reset_state("rst_mid");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        ack(3'd4, 3'd0);
        check_reset_state("late_ack");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
